spr_de_gamma_pwl: RTL and testbench
===================================

SPR_DE_GAMMA_PWL -- requirements
Module: spr_de_gamma_pwl

Interface
REQ-001 SHALL have parameter CH, default 8, number of parallel sub-pixel channels.
REQ-002 SHALL have parameter IW, default 11, input sample width (IW >= 6).
REQ-003 SHALL have parameter OW, default 8, output sample width (5 <= OW <= 12).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports i_hs, i_vs  in  1 each  input sync strobes.
REQ-007 SHALL have port i_valid  in  1  input sample-vector qualifier.
REQ-008 SHALL have port spr_de_gamma_in  in  CH*IW  channel k at bits [k*IW +: IW].
REQ-009 SHALL have port bypass  in  1  truncation instead of the curve.
REQ-010 SHALL have ports lut_we (1), lut_addr (6), lut_wdata (OW), all inputs: knot write port.
REQ-011 SHALL have ports o_hs, o_vs, o_valid  out  1 each  delayed syncs and qualifier.
REQ-012 SHALL have port spr_de_gamma_out  out  CH*OW  channel k at bits [k*OW +: OW].
REQ-013 SHALL have port lut_pending  out  1  shadow table holds unapplied writes.

Function
REQ-014 SHALL map each channel through one shared 33-knot piecewise-linear curve: idx = in[IW-1 -: 5], frac = lower FB = IW-5 bits.
REQ-015 SHALL compute out = sat(k[idx] + ((signed(k[idx+1]-k[idx])*frac + 2^(FB-1)) >>> FB)), saturated to [0, 2^OW-1].
REQ-016 SHALL, with bypass=1, output in >> (IW-OW) (zero-extended if OW > IW) at the same latency.
REQ-017 SHALL have fixed 3-cycle latency from in/i_valid/i_hs/i_vs to out/o_valid/o_hs/o_vs; there is no backpressure.
REQ-018 SHALL hold spr_de_gamma_out at its last value while o_valid=0.
REQ-019 SHALL write lut_wdata to shadow knot lut_addr on lut_we for addr 0..32; SHALL ignore addr 33..63.
REQ-020 SHALL set lut_pending on any accepted write and copy shadow to active on the first cycle after an i_vs rising edge (registered i_vs 0->1) while pending.
REQ-021 SHALL clear lut_pending on copy unless a write occurs in the same cycle (set wins); the copy uses the pre-write shadow.
REQ-022 SHALL apply the active table to samples entering after the copy cycle; in-flight samples complete with the old table.

Reset
REQ-023 SHALL, while rst_n=0, drive o_valid, o_hs, o_vs, lut_pending and spr_de_gamma_out to 0 and clear the pipeline.
REQ-024 SHALL reset the active and shadow knots to identity: k[i] = min(i << (OW-5), 2^OW-1).
REQ-025 SHALL abandon a mid-frame table update on reset, leaving no partial table.

Configuration
REQ-026 SHALL, with SPR_DE_GAMMA_DBUF_EN defined, implement the shadow/active double buffer of REQ-020 to REQ-022.
REQ-027 SHALL, without SPR_DE_GAMMA_DBUF_EN, write directly to the active table (taking effect on the next input sample), omit the shadow table, and tie lut_pending to 0.

Structure
REQ-028 SHALL take KNOT_BITS=5, NKNOT=33 and the identity-knot function from shared package spr_pkg.
REQ-029 SHALL instantiate sub-module spr_pwl_interp CH times: one per-channel 3-stage lookup/multiply/round-saturate datapath receiving the active knots.

Verification (defaults CH=8, IW=11, OW=8)
REQ-030 SHALL check post-reset identity: all channels in=1024 with i_valid -> out=128 and o_valid=1 exactly 3 cycles later; in=0 -> 0; in=2047 -> 255.
REQ-031 SHALL check double buffering: write k[16]=200, in=1024 before the vs edge -> 128 and lut_pending=1; after the i_vs rising edge -> 200 and lut_pending=0.
REQ-032 SHALL check a negative slope: k[0]=100, k[1]=0 applied, in=32 -> out=50.
REQ-033 SHALL check bypass: in=1027, bypass=1 -> out=128 at 3-cycle latency, and o_hs/o_vs pulses are delayed 3 cycles.
REQ-034 SHALL check edge cases: a write to addr 40 is ignored; a write coinciding with the copy cycle leaves lut_pending=1; rst_n low mid-stream -> outputs 0 and knots identity.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared constants and helpers for the sub-pixel rendering de-gamma curve.
package spr_pkg;

  // The top 5 input bits select a curve segment. There are 32 segments, so 33 knots.
  localparam int unsigned KNOT_BITS = 5;
  localparam int unsigned NKNOT     = 33;

  // Knot value for an identity curve: i << (ow-5), clamped to full scale.
  function automatic int unsigned ident_knot(int unsigned idx, int unsigned ow);
    int unsigned v;
    int unsigned m;
    v = idx << (ow - KNOT_BITS);
    m = (32'd1 << ow) - 32'd1;
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/spr_pwl_interp.sv
// One channel of the de-gamma curve. The datapath has three registered stages:
// knot lookup, slope multiply, then round/saturate (or truncation in bypass).
module spr_pwl_interp
  import spr_pkg::*;
#(
  parameter int unsigned IW = 11,
  parameter int unsigned OW = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          en_i,      // per-stage advance: {stage3, stage2, stage1}
  input  logic                bypass_i,
  input  logic [IW-1:0]       in_i,
  input  logic [NKNOT*OW-1:0] knots_i,
  output logic [OW-1:0]       out_o
);

  localparam int unsigned FB  = IW - KNOT_BITS;
  localparam int unsigned PW  = OW + FB + 2;
  localparam int unsigned XW  = KNOT_BITS + 1;
  localparam int unsigned BSh = (IW >= OW) ? IW - OW : 0;
  localparam logic signed [PW-1:0] Rnd = PW'(1 << (FB - 1));
  localparam logic signed [PW-1:0] Max = PW'((1 << OW) - 1);

  logic [KNOT_BITS-1:0]  idx;
  logic [XW-1:0]         idx_n;
  logic [OW-1:0]         lo_d, hi_d, byp_d;
  logic [OW-1:0]         lo_q, hi_q, byp1_q, base_q, byp2_q, out_q, out_d;
  logic [FB-1:0]         frac_q;
  logic                  sel1_q, sel2_q;
  logic signed [PW-1:0]  diff, fs, prod_d, prod_q, shifted, acc;

  // Stage 1 select: the segment's two end knots and the truncated bypass value.
  always_comb begin
    idx   = in_i[IW-1 -: KNOT_BITS];
    idx_n = XW'(idx) + XW'(1);
    lo_d  = knots_i[idx * OW +: OW];
    hi_d  = knots_i[idx_n * OW +: OW];
    byp_d = OW'(in_i >> BSh);
  end

  // Stage 2: signed slope times fraction. The fraction is zero-extended so it stays positive.
  always_comb begin
    diff   = $signed(PW'(hi_q)) - $signed(PW'(lo_q));
    fs     = $signed(PW'(frac_q));
    prod_d = diff * fs;
  end

  // Stage 3: round half up, add the base knot, then clamp to [0, 2^OW-1].
  always_comb begin
    shifted = (prod_q + Rnd) >>> FB;
    acc     = shifted + $signed(PW'(base_q));
    if (sel2_q) begin
      out_d = byp2_q;
    end else if (acc[PW-1]) begin
      out_d = '0;
    end else if (acc > Max) begin
      out_d = '1;
    end else begin
      out_d = acc[OW-1:0];
    end
  end

  // Pipeline registers. Each stage advances only with its valid, so the output holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q   <= '0;
      hi_q   <= '0;
      frac_q <= '0;
      byp1_q <= '0;
      sel1_q <= 1'b0;
      prod_q <= '0;
      base_q <= '0;
      byp2_q <= '0;
      sel2_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (en_i[0]) begin
        lo_q   <= lo_d;
        hi_q   <= hi_d;
        frac_q <= in_i[FB-1:0];
        byp1_q <= byp_d;
        sel1_q <= bypass_i;
      end
      if (en_i[1]) begin
        prod_q <= prod_d;
        base_q <= lo_q;
        byp2_q <= byp1_q;
        sel2_q <= sel1_q;
      end
      if (en_i[2]) begin
        out_q <= out_d;
      end
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/spr_de_gamma_pwl.sv
// De-gamma for sub-pixel rendering. It maps CH channels through one shared 33-knot
// piecewise-linear curve, with a fixed latency of 3 cycles.
// Define SPR_DE_GAMMA_DBUF_EN to get a shadow knot table. That table is copied into the
// active table at the frame boundary (i_vs rising). Without the macro, knot writes go
// straight to the active table.
module spr_de_gamma_pwl
  import spr_pkg::*;
#(
  parameter int unsigned CH = 8,
  parameter int unsigned IW = 11,
  parameter int unsigned OW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_valid,
  input  logic [CH*IW-1:0] spr_de_gamma_in,
  input  logic             bypass,
  input  logic             lut_we,
  input  logic [5:0]       lut_addr,
  input  logic [OW-1:0]    lut_wdata,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_valid,
  output logic [CH*OW-1:0] spr_de_gamma_out,
  output logic             lut_pending
);

  logic [2:0]          valid_q, hs_q, vs_q;
  logic                wr_ok;
  logic [OW-1:0]       act_q [NKNOT];
  logic [NKNOT*OW-1:0] knots;

  assign wr_ok = lut_we && (lut_addr < 6'(NKNOT));

  // Delay line for the qualifier and syncs. It matches the 3-stage datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
    end else begin
      valid_q <= {valid_q[1:0], i_valid};
      hs_q    <= {hs_q[1:0], i_hs};
      vs_q    <= {vs_q[1:0], i_vs};
    end
  end

  assign o_valid = valid_q[2];
  assign o_hs    = hs_q[2];
  assign o_vs    = vs_q[2];

`ifdef SPR_DE_GAMMA_DBUF_EN
  logic [OW-1:0] shd_q [NKNOT];
  logic          pend_q;
  logic          copy;

  // Copy in the cycle after registered i_vs goes 0->1, but only when writes are waiting.
  assign copy = vs_q[0] & ~vs_q[1] & pend_q;

  // Shadow/active tables. The copy reads the shadow before any same-cycle write, and a
  // same-cycle write keeps the table marked pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NKNOT; i++) begin
        act_q[i] <= OW'(ident_knot(i, OW));
        shd_q[i] <= OW'(ident_knot(i, OW));
      end
      pend_q <= 1'b0;
    end else begin
      if (copy) begin
        act_q <= shd_q;
      end
      if (wr_ok) begin
        shd_q[lut_addr] <= lut_wdata;
      end
      pend_q <= wr_ok | (pend_q & ~copy);
    end
  end

  assign lut_pending = pend_q;
`else
  // Single table. A write is seen by the next sample that enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NKNOT; i++) begin
        act_q[i] <= OW'(ident_knot(i, OW));
      end
    end else if (wr_ok) begin
      act_q[lut_addr] <= lut_wdata;
    end
  end

  assign lut_pending = 1'b0;
`endif

  // Flatten the active knots so every channel gets the same table.
  always_comb begin
    knots = '0;
    for (int unsigned i = 0; i < NKNOT; i++) begin
      knots[i*OW +: OW] = act_q[i];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    spr_pwl_interp #(
      .IW(IW),
      .OW(OW)
    ) u_interp (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    ({valid_q[1:0], i_valid}),
      .bypass_i(bypass),
      .in_i    (spr_de_gamma_in[c*IW +: IW]),
      .knots_i (knots),
      .out_o   (spr_de_gamma_out[c*OW +: OW])
    );
  end

endmodule

// File: tb/tb_spr_de_gamma_pwl.sv
// Directed bench for spr_de_gamma_pwl at its default parameters (CH=8, IW=11, OW=8).
// A reference model of the knot table builds the expected outputs. Those go into a
// scoreboard queue when each cycle is driven, and come out for comparison 3 cycles later.
module tb_spr_de_gamma_pwl;

  localparam int CH = 8;
  localparam int IW = 11;
  localparam int OW = 8;
`ifdef SPR_DE_GAMMA_DBUF_EN
  localparam bit Dbuf = 1'b1;
`else
  localparam bit Dbuf = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             i_hs = 1'b0, i_vs = 1'b0, i_valid = 1'b0, bypass = 1'b0, lut_we = 1'b0;
  logic [CH*IW-1:0] din = '0;
  logic [5:0]       lut_addr = '0;
  logic [OW-1:0]    lut_wdata = '0;
  logic             o_hs, o_vs, o_valid, lut_pending;
  logic [CH*OW-1:0] dout;

  spr_de_gamma_pwl #(.CH(CH), .IW(IW), .OW(OW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_hs            (i_hs),
    .i_vs            (i_vs),
    .i_valid         (i_valid),
    .spr_de_gamma_in (din),
    .bypass          (bypass),
    .lut_we          (lut_we),
    .lut_addr        (lut_addr),
    .lut_wdata       (lut_wdata),
    .o_hs            (o_hs),
    .o_vs            (o_vs),
    .o_valid         (o_valid),
    .spr_de_gamma_out(dout),
    .lut_pending     (lut_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             v;
    logic             hs;
    logic             vs;
    logic [CH*OW-1:0] d;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad = 0;
  int               ma[33];
  int               ms[33];
  bit               mpend, mvs0, mvs1;
  logic [CH*OW-1:0] mlast;
  int               chv[CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ident(int i);
    return (i * 8 > 255) ? 255 : i * 8;
  endfunction

  // Reference curve: the rounded, floor-shifted linear interpolation, then clamped.
  function automatic int curve(int x);
    int idx, fr, t, v;
    idx = x >> 6;
    fr  = x & 63;
    t   = (ma[idx+1] - ma[idx]) * fr + 32;
    v   = ma[idx] + (t >>> 6);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 33; i++) begin
      ma[i] = ident(i);
      ms[i] = ident(i);
    end
    mpend = 0;
    mvs0  = 0;
    mvs1  = 0;
    mlast = '0;
    sb.delete();
  endtask

  task automatic set_all(input int x);
    for (int c = 0; c < CH; c++) chv[c] = x;
  endtask

  // One clock cycle of stimulus. Pushes this cycle's expected output and advances the table model.
  task automatic step(input bit v, input bit hs, input bit vs, input bit byp,
                      input bit we, input int addr, input int wdata);
    exp_t e;
    i_valid   = v;
    i_hs      = hs;
    i_vs      = vs;
    bypass    = byp;
    lut_we    = we;
    lut_addr  = 6'(addr);
    lut_wdata = OW'(wdata);
    for (int c = 0; c < CH; c++) din[c*IW +: IW] = IW'(chv[c]);
    if (v) begin
      for (int c = 0; c < CH; c++) mlast[c*OW +: OW] = OW'(byp ? (chv[c] >> 3) : curve(chv[c]));
    end
    e.v  = v;
    e.hs = hs;
    e.vs = vs;
    e.d  = mlast;
    @(posedge clk);
    sb.push_back(e);
    if (Dbuf) begin
      if (mvs0 && !mvs1 && mpend) begin
        ma    = ms;
        mpend = 0;
      end
      if (we && addr < 33) begin
        ms[addr] = wdata;
        mpend    = 1;
      end
    end else if (we && addr < 33) begin
      ma[addr] = wdata;
    end
    mvs1 = mvs0;
    mvs0 = vs;
    #1;
    lut_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample(input bit byp);
    step(1, 0, 0, byp, 0, 0, 0);
  endtask

  task automatic write(input int addr, input int wdata);
    step(0, 0, 0, 0, 1, addr, wdata);
  endtask

  task automatic vs_pulse();
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {61'd0, o_valid, o_hs, o_vs}, 64'd0);
    chk({tag, "_out"}, dout, 64'd0);
    chk({tag, "_pend"}, lut_pending, 64'd0);
  endtask

  // Output-side scoreboard. It compares every cycle once three cycles are in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() == 3) begin
      e = sb.pop_front();
      chk("o_valid", o_valid, e.v);
      chk("o_hs", o_hs, e.hs);
      chk("o_vs", o_vs, e.vs);
      chk("out", dout, e.d);
    end
  end

  initial begin
    model_reset();
    set_all(0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    idle(2);

    // Identity curve after reset: 1024->128, 0->0, 2047->255, then mixed and random values.
    set_all(1024); sample(0);
    set_all(0);    sample(0);
    set_all(2047); sample(0);
    for (int c = 0; c < CH; c++) chv[c] = c * 250 + 7;
    sample(0);
    idle(1);
    repeat (6) begin
      for (int c = 0; c < CH; c++) chv[c] = $urandom_range(0, 2047);
      sample(0);
    end
    idle(3);

    // Knot write: with the double buffer it is held until the frame boundary.
    write(16, 200);
    chk("pend_after_write", lut_pending, Dbuf);
    set_all(1024); sample(0);
    idle(3);
    vs_pulse();
    set_all(1024); sample(0);
    idle(3);
    chk("pend_after_copy", lut_pending, 0);

    // Negative slope segment: k0=100, k1=0, in=32 -> 50.
    write(0, 100);
    write(1, 0);
    vs_pulse();
    set_all(32); sample(0);
    idle(3);

    // Bypass truncation, plus sync pulses through the delay line.
    set_all(1027); sample(1);
    for (int c = 0; c < CH; c++) chv[c] = c * 255 + 3;
    sample(1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(4);

    // A write to an address outside the table is ignored (it must not alias onto k[8]).
    write(40, 77);
    chk("pend_addr40", lut_pending, 0);
    vs_pulse();
    set_all(512); sample(0);
    idle(3);

    // A write in the copy cycle keeps pending set. The copy takes the pre-write shadow.
    write(20, 10);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 21, 30);
    chk("pend_coincide", lut_pending, Dbuf);
    step(0, 0, 0, 0, 0, 0, 0);
    set_all(1280); sample(0);
    set_all(1344); sample(0);
    idle(3);
    vs_pulse();
    set_all(1344); sample(0);
    idle(3);
    chk("pend_final_copy", lut_pending, 0);

    // Reset mid-stream: outputs clear, in-flight data is dropped, knots go back to identity.
    write(5, 3);
    set_all(1500); sample(0);
    sample(0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    #1 rst_n = 1'b1;
    set_all(1280); sample(0);
    set_all(320);  sample(0);
    idle(3);
    chk("pend_post_reset", lut_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
